// File: rtl/frac_lut.sv
// frac_lut: fracturable LUT whose truth table is loaded through a daisy-chained shift register.
// Define FRAC_LUT_REG_OUT_EN to register out0/out1 (1-cycle latency); otherwise they are combinational.
module frac_lut #(
   parameter int INPUTS       = 4,
   parameter int MEM_SIZE     = 2**INPUTS,
   parameter int CONFIG_WIDTH = 1
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    config_en,
   input  logic [CONFIG_WIDTH-1:0] config_in,
   output logic [CONFIG_WIDTH-1:0] config_out,
   input  logic                    frac_mode,
   input  logic [INPUTS-1:0]       addr,
   output logic                    out0,
   output logic                    out1,
   output logic                    config_done
);

   localparam int LOADING_CYCLES = MEM_SIZE / CONFIG_WIDTH;
   localparam int CNT_W          = $clog2(LOADING_CYCLES + 1);

   if (INPUTS < 2 || MEM_SIZE != 2**INPUTS || (MEM_SIZE % CONFIG_WIDTH) != 0) begin : g_bad_params
      $error("frac_lut: illegal INPUTS/MEM_SIZE/CONFIG_WIDTH combination");
   end

   logic [MEM_SIZE-1:0] mem;
   logic [MEM_SIZE-1:0] mem_shifted;
   logic [CNT_W-1:0]    cnt;

   // Written as shift-then-insert so it stays legal even when CONFIG_WIDTH == MEM_SIZE.
   always_comb begin
      mem_shifted                   = mem << CONFIG_WIDTH;
      mem_shifted[CONFIG_WIDTH-1:0] = config_in;
   end

   // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values;
   // mem is a plain flop vector (not a RAM macro), so it is reset along with cnt.
   always_ff @(posedge clk) begin
      if (rst) begin
         mem <= '0;
         cnt <= '0;
      end else if (config_en) begin
         mem <= mem_shifted;
         if (cnt != CNT_W'(LOADING_CYCLES))
            cnt <= cnt + CNT_W'(1);
      end
   end

   assign config_done = (cnt == CNT_W'(LOADING_CYCLES));
   assign config_out  = mem[MEM_SIZE-1 -: CONFIG_WIDTH];

   logic [INPUTS-1:0] lo_idx;
   logic [INPUTS-1:0] hi_idx;
   logic              lut0;
   logic              lut1;
   logic              out_en;

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      lo_idx = addr;
      hi_idx = addr;
      lut1   = 1'b0;
      if (frac_mode) begin
         // Fractured: the MSB picks the half, so lower and upper halves share addr[INPUTS-2:0].
         lo_idx[INPUTS-1] = 1'b0;
         hi_idx[INPUTS-1] = 1'b1;
         lut1             = mem[hi_idx];
      end
      lut0   = mem[lo_idx];
      out_en = config_done & ~config_en;
   end

`ifdef FRAC_LUT_REG_OUT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         out0 <= 1'b0;
         out1 <= 1'b0;
      end else begin
         out0 <= lut0 & out_en;
         out1 <= lut1 & out_en;
      end
   end
`else
   assign out0 = lut0 & out_en;
   assign out1 = lut1 & out_en;
`endif

endmodule

// File: doc/frac_lut.md
FRAC_LUT -- requirements
Module: frac_lut

Interface
REQ-001: Parameter INPUTS, default 4, SHALL set the LUT address width, minimum 2.
REQ-002: Parameter MEM_SIZE, default 2**INPUTS, SHALL set the configuration memory depth in bits and SHALL equal 2**INPUTS.
REQ-003: Parameter CONFIG_WIDTH, default 1, SHALL set the shift-chain width in bits per cycle and SHALL divide MEM_SIZE.
REQ-004: Derived constant LOADING_CYCLES SHALL equal MEM_SIZE/CONFIG_WIDTH.
REQ-005: Port clk, input, 1, is the single clock for configuration and output logic.
REQ-006: Port rst, input, 1, is a synchronous active-high reset.
REQ-007: Port config_en, input, 1, enables one shift of the configuration chain per clk.
REQ-008: Port config_in, input, CONFIG_WIDTH, carries chain data in.
REQ-009: Port config_out, output, CONFIG_WIDTH, carries chain data out to the next LUT.
REQ-010: Port frac_mode, input, 1, selects fractured mode when high.
REQ-011: Port addr, input, INPUTS, is the LUT address.
REQ-012: Port out0, output, 1, is the primary LUT output.
REQ-013: Port out1, output, 1, is the secondary (fractured) LUT output.
REQ-014: Port config_done, output, 1, is high once a full configuration load has been accepted.

Function
REQ-015: On a clk edge with config_en=1, mem SHALL become {mem[MEM_SIZE-CONFIG_WIDTH-1:0], config_in}, so the first word shifted in ends in mem[MEM_SIZE-1 -: CONFIG_WIDTH].
REQ-016: config_out SHALL continuously equal mem[MEM_SIZE-1 -: CONFIG_WIDTH], giving a one-shift-per-LUT daisy chain.
REQ-017: With config_en=0, mem SHALL hold.
REQ-018: Load counter cnt SHALL increment on each config_en cycle and saturate at LOADING_CYCLES.
REQ-019: If config_en drops mid-load, cnt SHALL hold and the load SHALL resume on the next config_en cycle.
REQ-020: config_done SHALL be high whenever cnt==LOADING_CYCLES.
REQ-021: Shifts after saturation SHALL continue to move data (pass-through), and config_done SHALL stay 1.
REQ-022: With frac_mode=0, out0 SHALL be mem[addr] and out1 SHALL be 0.
REQ-023: With frac_mode=1, out0 SHALL be mem[addr[INPUTS-2:0]] and out1 SHALL be mem[MEM_SIZE/2 + addr[INPUTS-2:0]]; addr[INPUTS-1] is ignored.
REQ-024: out0 and out1 SHALL be forced to 0 while config_done=0 or config_en=1.
REQ-025: frac_mode and addr changes SHALL take effect with the latency defined in Configuration and without disturbing mem.

Reset
REQ-026: rst=1 at a clk edge SHALL clear mem to 0, cnt to 0, config_done to 0, and any output registers to 0.
REQ-027: rst SHALL take priority over config_en in the same cycle.
REQ-028: Reset during a load SHALL abort it; a fresh LOADING_CYCLES shifts SHALL be required to set config_done again.
REQ-029: config_out SHALL be 0 in the cycle after reset.

Configuration
REQ-030: When FRAC_LUT_REG_OUT_EN is defined, out0 and out1 SHALL be registered on clk, giving 1-cycle latency from addr, frac_mode, config_done and config_en to output, with a reset value of 0.
REQ-031: When FRAC_LUT_REG_OUT_EN is undefined, out0 and out1 SHALL be combinational with 0-cycle latency; all other behaviour is identical.

Verification (INPUTS=4, CONFIG_WIDTH=1)
REQ-032: Reset, then shift 16'hA5C3 MSB-first over 16 cycles -> config_done rises after the 16th edge; addr 0 -> out0=1, addr 2 -> out0=0, addr 15 -> out0=1, out1=0.
REQ-033: After the same load, frac_mode=1, addr=4'b0010 -> out0=0 (C3 bit2), out1=1 (A5 bit2); addr=4'b1010 gives the same result.
REQ-034: Shift 8 bits, drop config_en for 5 cycles, shift 8 more -> config_done=0 during the gap, 1 after bit 16, mem=pattern.
REQ-035: Two chained instances, shift 32 bits 32'h1234ABCD -> first instance mem=16'hABCD, second instance mem=16'h1234, both config_done=1.
REQ-036: Assert rst at shift 10 -> config_done=0, config_out=0, outputs 0; a full reload then restores correct outputs.
REQ-037: With FRAC_LUT_REG_OUT_EN defined, changing addr from 0 to 2 -> out0 changes exactly one clk later.
